decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, parametrised instruction-decode pipeline stage for the RISC core.
//  - Splits each instruction into opcode, fn, register indices and a sign-extended immediate.
//  - Tracks in-flight register writes in a scoreboard and stalls fetch on RAW/WAW hazards.
//  - Sits between fetch and execute, with valid/ready handshakes on both sides and a flush input.
//  - Unused fields are driven to 0 (never X); the opcode map has no duplicate entries.
// PARAMETERS
//  INST_W  16  instruction width; must be >= 4+2*REG_W+1
//  REG_W   3   register index width; NREGS = 2**REG_W
//  IMM_W   (derived) INST_W-4-2*REG_W, width of the short immediate field
// PORTS
//  clk        in   1        clock; everything samples on its rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        fetch presents in_inst
//  in_ready   out  1        stage accepts in_inst this cycle
//  in_inst    in   INST_W   instruction word
//  out_valid  out  1        decoded fields are valid
//  out_ready  in   1        execute consumes the decoded fields
//  opcode_o   out  3        inst[2:0]
//  fn_o       out  1        inst[3]
//  rd_o       out  REG_W    destination register (LOAD/ALU/MOVE), else 0
//  rs1_o      out  REG_W    source 1 (inst[4+:REG_W]) when used, else 0
//  rs2_o      out  REG_W    source 2 (inst[4+REG_W+:REG_W]) when used, else 0
//  imm_o      out  INST_W-4 immediate; meaning set by opcode, else 0
//  we_o       out  1        instruction writes rd
//  illegal_o  out  1        encoding is illegal; all other field outputs are 0
//  flush      in   1        discard the instruction held in the output register
//  wb_valid   in   1        writeback of register wb_rd completes this cycle
//  wb_rd      in   REG_W    register whose pending bit is cleared
// BEHAVIOUR
//  Opcode map (fields: A = inst[4+:REG_W], B = inst[4+REG_W+:REG_W], S = inst[INST_W-1-:IMM_W] sign-extended):
//   000 NAND/NOR, 011 ADD/SUB, 100 SRL/SLL: rd=A, rs1=A, rs2=B, we=1
//   001 BLT, 101 BEQ: rs1=A, rs2=B, imm=S, we=0; fn must be 0
//   010 LOAD: rd=A, rs2=B (base), imm=S, we=1; fn must be 0
//   110 STORE: rs1=A (data), rs2=B (base), imm=S, we=0; fn must be 0
//   111 fn=1 JUMP: imm=inst[INST_W-1:4] (raw, no extension), we=0
//   111 fn=0 MOVE: rd=A, rs2=B, we=1
//   If fn=1 where it must be 0: illegal_o=1 and we=0; the instruction still passes downstream.
//  Handshake:
//   - Output register loads on (in_valid && in_ready).
//   - out_valid rises the next cycle (latency 1).
//   - Output register holds steady while (out_valid && !out_ready).
//   - in_ready = (!out_valid || out_ready) && !hazard && !flush.
//  Scoreboard (pending[NREGS]):
//   - Set bit rd on issue (out_valid && out_ready && we_o).
//   - Clear bit wb_rd when wb_valid is high.
//   - Same register set and cleared in one cycle: set wins.
//  hazard (combinational, on in_inst):
//   - A used source, or the rd of a writing instruction, matches either
//     (pending bit that is not being cleared this cycle) or (out_valid && we_o && rd_o).
//   - A same-cycle wb clear bypasses the hazard.
//  flush:
//   - out_valid=0 the next cycle; the input is not accepted that cycle.
//   - pending is untouched, because issued instructions still write back.
//  Reset: out_valid=0, pending=0, and all field outputs =0; in_ready=1 in the first cycle after reset.
// TESTING
//  1 Reset then ADD r1,r2 (INST_W=16): out_valid=1 one cycle later, rd_o=1, rs2_o=2, we_o=1, imm_o=0.
//  2 BEQ with S=6'b111110: imm_o=12'hFFE; BEQ with fn=1: illegal_o=1, we_o=0, rs1_o=0.
//  3 out_ready=0 for 3 cycles: fields unchanged, in_ready=0, no instruction dropped or duplicated.
//  4 LOAD r3 issued, then ADD r4,r3: in_ready=0 until wb_valid with wb_rd=3; accepted that same cycle.
//  5 flush while out_valid=1: out_valid=0 next cycle, pending unchanged; wb_valid && issue on the same rd: bit stays 1.
//  6 rst asserted mid-stall: next cycle out_valid=0, pending=0, in_ready=1.

Source files
------------

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: splits the instruction word into fields and tracks
// in-flight register writes so that fetch stalls on RAW/WAW hazards.
module decode_stage #(
  parameter int INST_W = 16,
  parameter int REG_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_W-1:0]   in_inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          opcode_o,
  output logic                fn_o,
  output logic [REG_W-1:0]    rd_o,
  output logic [REG_W-1:0]    rs1_o,
  output logic [REG_W-1:0]    rs2_o,
  output logic [INST_W-5:0]   imm_o,
  output logic                we_o,
  output logic                illegal_o,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd
);

  localparam int IMM_W = INST_W - 4 - 2*REG_W;
  localparam int IW    = INST_W - 4;
  localparam int NREGS = 1 << REG_W;

  function automatic logic signed [IW-1:0] sext_imm(input logic [IMM_W-1:0] s);
    return {{(IW-IMM_W){s[IMM_W-1]}}, s};
  endfunction

  logic [2:0]       d_opcode;
  logic             d_fn, d_we, d_ill, use_rs1, use_rs2;
  logic [REG_W-1:0] d_rd, d_rs1, d_rs2, fa, fb;
  logic [IW-1:0]    d_imm;
  logic [2:0]       op;
  logic             fn;

  assign op = in_inst[2:0];
  assign fn = in_inst[3];
  assign fa = in_inst[4 +: REG_W];
  assign fb = in_inst[4+REG_W +: REG_W];

  // Field decode; illegal encodings leave every field at zero.
  always_comb begin
    d_opcode = '0;
    d_fn     = 1'b0;
    d_rd     = '0;
    d_rs1    = '0;
    d_rs2    = '0;
    d_imm    = '0;
    d_we     = 1'b0;
    d_ill    = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (op)
      3'b000, 3'b011, 3'b100: begin
        d_rd = fa; d_rs1 = fa; d_rs2 = fb; d_we = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      3'b001, 3'b101, 3'b110: begin
        if (fn) d_ill = 1'b1;
        else begin
          d_rs1 = fa; d_rs2 = fb; d_imm = sext_imm(in_inst[INST_W-1 -: IMM_W]);
          use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
      end
      3'b010: begin
        if (fn) d_ill = 1'b1;
        else begin
          d_rd = fa; d_rs2 = fb; d_imm = sext_imm(in_inst[INST_W-1 -: IMM_W]);
          d_we = 1'b1; use_rs2 = 1'b1;
        end
      end
      default: begin
        if (fn) d_imm = in_inst[INST_W-1:4];
        else begin
          d_rd = fa; d_rs2 = fb; d_we = 1'b1; use_rs2 = 1'b1;
        end
      end
    endcase
    if (!d_ill) begin
      d_opcode = op;
      d_fn     = fn;
    end
  end

  logic             vld_p0, fn_p0, we_p0, ill_p0;
  logic [2:0]       opcode_p0;
  logic [REG_W-1:0] rd_p0, rs1_p0, rs2_p0;
  logic [IW-1:0]    imm_p0;
  logic [NREGS-1:0] pending, busy, sb_set, sb_clr;
  logic             hazard, issue;

  assign issue = vld_p0 && out_ready && we_p0;

  // A register is busy if an older write is outstanding and not retiring this cycle,
  // or if the instruction sitting in the output register is about to write it.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (issue)    sb_set[rd_p0] = 1'b1;
    if (wb_valid) sb_clr[wb_rd] = 1'b1;
    for (int i = 0; i < NREGS; i++)
      busy[i] = (pending[i] && !sb_clr[i]) || (vld_p0 && we_p0 && (rd_p0 == REG_W'(i)));
  end

  assign hazard   = (use_rs1 && busy[d_rs1]) || (use_rs2 && busy[d_rs2]) || (d_we && busy[d_rd]);
  assign in_ready = (!vld_p0 || out_ready) && !hazard && !flush;

  // Stage p0: output register and scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      pending   <= '0;
      opcode_p0 <= '0;
      fn_p0     <= 1'b0;
      rd_p0     <= '0;
      rs1_p0    <= '0;
      rs2_p0    <= '0;
      imm_p0    <= '0;
      we_p0     <= 1'b0;
      ill_p0    <= 1'b0;
    end else begin
      pending <= (pending & ~sb_clr) | sb_set;
      if (flush) begin
        vld_p0 <= 1'b0;
      end else if (in_valid && in_ready) begin
        vld_p0    <= 1'b1;
        opcode_p0 <= d_opcode;
        fn_p0     <= d_fn;
        rd_p0     <= d_rd;
        rs1_p0    <= d_rs1;
        rs2_p0    <= d_rs2;
        imm_p0    <= d_imm;
        we_p0     <= d_we;
        ill_p0    <= d_ill;
      end else if (out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p0;
  assign opcode_o  = opcode_p0;
  assign fn_o      = fn_p0;
  assign rd_o      = rd_p0;
  assign rs1_o     = rs1_p0;
  assign rs2_o     = rs2_p0;
  assign imm_o     = imm_p0;
  assign we_o      = we_p0;
  assign illegal_o = ill_p0;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, handshake stalls, hazards, flush and reset.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_inst;
  logic [2:0]  opcode_o;
  logic        fn_o, we_o, illegal_o, flush, wb_valid;
  logic [2:0]  rd_o, rs1_o, rs2_o, wb_rd;
  logic [11:0] imm_o;

  int errors = 0;
  int checks = 0;

  decode_stage #(.INST_W(16), .REG_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .opcode_o(opcode_o), .fn_o(fn_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .we_o(we_o),
    .illegal_o(illegal_o), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [2:0] op, input logic f,
                                      input logic [2:0] a, input logic [2:0] b,
                                      input logic [5:0] s);
    return {s, b, a, f, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;
    flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_pending", dut.pending, 0);
    chk("rst_in_ready", in_ready, 1);

    // ADD r1,r2
    in_inst = enc(3'b011, 1'b0, 3'd1, 3'd2, 6'd0); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_opcode", opcode_o, 3);
    chk("add_rd", rd_o, 1);
    chk("add_rs1", rs1_o, 1);
    chk("add_rs2", rs2_o, 2);
    chk("add_we", we_o, 1);
    chk("add_imm", imm_o, 0);
    tick();
    chk("add_issued_valid", out_valid, 0);
    chk("add_pending", dut.pending, 8'h02);
    wb_valid = 1'b1; wb_rd = 3'd1;
    tick(); wb_valid = 1'b0;
    chk("add_wb_pending", dut.pending, 0);

    // BEQ r2,r3 with negative offset, then the fn=1 illegal form
    in_inst = enc(3'b101, 1'b0, 3'd2, 3'd3, 6'b111110); in_valid = 1'b1;
    tick();
    chk("beq_imm", imm_o, 12'hFFE);
    chk("beq_rs1", rs1_o, 2);
    chk("beq_rs2", rs2_o, 3);
    chk("beq_rd", rd_o, 0);
    chk("beq_we", we_o, 0);
    chk("beq_illegal", illegal_o, 0);
    in_inst = enc(3'b101, 1'b1, 3'd2, 3'd3, 6'b111110);
    tick(); in_valid = 1'b0;
    chk("beqf_valid", out_valid, 1);
    chk("beqf_illegal", illegal_o, 1);
    chk("beqf_we", we_o, 0);
    chk("beqf_rs1", rs1_o, 0);
    chk("beqf_imm", imm_o, 0);
    chk("beqf_opcode", opcode_o, 0);
    tick();

    // Back-pressure: MOVE r5,r6 held for 3 cycles while STORE waits
    out_ready = 1'b0;
    in_inst = enc(3'b111, 1'b0, 3'd5, 3'd6, 6'd0); in_valid = 1'b1;
    tick();
    in_inst = enc(3'b110, 1'b0, 3'd0, 3'd7, 6'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_rd", rd_o, 5);
      chk("stall_rs2", rs2_o, 6);
      chk("stall_opcode", opcode_o, 7);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("unstall_in_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("store_valid", out_valid, 1);
    chk("store_opcode", opcode_o, 6);
    chk("store_rs1", rs1_o, 0);
    chk("store_rs2", rs2_o, 7);
    chk("store_imm", imm_o, 1);
    chk("move_pending", dut.pending, 8'h20);
    tick();
    chk("store_no_dup", out_valid, 0);
    wb_valid = 1'b1; wb_rd = 3'd5;
    tick(); wb_valid = 1'b0;

    // RAW: LOAD r3 then ADD r4,r3
    in_inst = enc(3'b010, 1'b0, 3'd3, 3'd0, 6'd0); in_valid = 1'b1;
    tick();
    in_inst = enc(3'b011, 1'b0, 3'd4, 3'd3, 6'd0); #1;
    chk("raw_out_hazard", in_ready, 0);
    tick(); #1;
    chk("raw_load_issued", out_valid, 0);
    chk("raw_pending", dut.pending, 8'h08);
    chk("raw_pend_hazard", in_ready, 0);
    tick();
    chk("raw_still_stalled", in_ready, 0);
    wb_valid = 1'b1; wb_rd = 3'd3; #1;
    chk("raw_wb_bypass", in_ready, 1);
    tick(); wb_valid = 1'b0; in_valid = 1'b0;
    chk("raw_accept_valid", out_valid, 1);
    chk("raw_accept_rd", rd_o, 4);
    chk("raw_accept_rs2", rs2_o, 3);
    chk("raw_wb_pending", dut.pending, 0);

    // Flush of the held ADD
    out_ready = 1'b0; flush = 1'b1; #1;
    chk("flush_in_ready", in_ready, 0);
    tick(); flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_pending", dut.pending, 0);
    out_ready = 1'b1;

    // Issue and writeback of the same register in one cycle: set wins
    in_inst = enc(3'b111, 1'b0, 3'd2, 3'd0, 6'd0); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("mv2_rd", rd_o, 2);
    wb_valid = 1'b1; wb_rd = 3'd2;
    tick(); wb_valid = 1'b0;
    chk("setwins_pending", dut.pending, 8'h04);

    // Flush leaves pending untouched
    in_inst = enc(3'b000, 1'b0, 3'd6, 3'd7, 6'd0); in_valid = 1'b1;
    tick(); in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush2_valid", out_valid, 0);
    chk("flush2_pending", dut.pending, 8'h04);

    // Reset in the middle of a stall
    in_inst = enc(3'b011, 1'b0, 3'd1, 3'd1, 6'd0); in_valid = 1'b1;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    in_inst = enc(3'b011, 1'b1, 3'd5, 3'd6, 6'd0); #1;
    chk("pre_rst_in_ready", in_ready, 0);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pending", dut.pending, 0);
    chk("mid_rst_rd", rd_o, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
